// File: rtl/alu_shift_stage.sv
// One stage of the slice barrel shifter: when enabled, takes the bit arriving
// from a neighbour slice, otherwise passes the previous stage through.
module alu_shift_stage (
  input  logic en_i,
  input  logic nbr_i,
  input  logic prev_i,
  output logic stage_o
);

  assign stage_o = en_i ? nbr_i : prev_i;

endmodule

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: full adder, six logic ops and one bit of an 8/4/2/1 barrel
// shifter, combined onto ALUOut with a registered copy on ALUOutQ.
module alu_bit_slice (
  input  logic Clock,
  input  logic nReset,
  input  logic A,
  input  logic B,
  input  logic SUB,
  input  logic ZeroA,
  input  logic CIn_Slice,
  output logic COut,
  output logic Sum,
  input  logic FAOut,
  input  logic nZ_prev,
  output logic nZ,
  input  logic AND,
  input  logic OR,
  input  logic XOR,
  input  logic NOT,
  input  logic NAND,
  input  logic NOR,
  input  logic Sh8,
  input  logic Sh4,
  input  logic Sh2,
  input  logic Sh1,
  input  logic ShB,
  input  logic ShL,
  input  logic ShR,
  input  logic ShOut,
  input  logic Sh8E_L,
  input  logic Sh4D_L,
  input  logic Sh2C_L,
  input  logic Sh1_L_In,
  input  logic Sh8D_R,
  input  logic Sh4C_R,
  input  logic Sh2B_R,
  input  logic Sh1_R_In,
  output logic Sh8A_L,
  output logic Sh4A_L,
  output logic Sh2A_L,
  output logic Sh1_L_Out,
  output logic Sh8Z_R,
  output logic Sh4Z_R,
  output logic Sh2Z_R,
  output logic Sh1_R_Out,
  output logic ALUOut,
  output logic ALUOutQ
);

  logic fa1, fa2;
  logic src, s8, s4, s2, s1;
  logic nin8, nin4, nin2, nin1;
  logic drv_l, drv_r;
  logic aluout_q;

  assign fa1  = A & ~ZeroA;
  assign fa2  = B ^ SUB;
  assign Sum  = fa1 ^ fa2 ^ CIn_Slice;
  assign COut = (fa1 & fa2) | (CIn_Slice & (fa1 ^ fa2));
  assign nZ   = nZ_prev | Sum;

  // Left direction has priority when both shift directions are requested.
  assign drv_l = ShL;
  assign drv_r = ShR & ~ShL;

  assign src  = ShB ? B : A;
  assign nin8 = drv_l ? Sh8E_L   : (drv_r ? Sh8D_R   : 1'b0);
  assign nin4 = drv_l ? Sh4D_L   : (drv_r ? Sh4C_R   : 1'b0);
  assign nin2 = drv_l ? Sh2C_L   : (drv_r ? Sh2B_R   : 1'b0);
  assign nin1 = drv_l ? Sh1_L_In : (drv_r ? Sh1_R_In : 1'b0);

  alu_shift_stage u_stage8 (.en_i(Sh8), .nbr_i(nin8), .prev_i(src), .stage_o(s8));
  alu_shift_stage u_stage4 (.en_i(Sh4), .nbr_i(nin4), .prev_i(s8),  .stage_o(s4));
  alu_shift_stage u_stage2 (.en_i(Sh2), .nbr_i(nin2), .prev_i(s4),  .stage_o(s2));
  alu_shift_stage u_stage1 (.en_i(Sh1), .nbr_i(nin1), .prev_i(s2),  .stage_o(s1));

  assign Sh8A_L    = drv_l & src;
  assign Sh4A_L    = drv_l & s8;
  assign Sh2A_L    = drv_l & s4;
  assign Sh1_L_Out = drv_l & s2;
  assign Sh8Z_R    = drv_r & src;
  assign Sh4Z_R    = drv_r & s8;
  assign Sh2Z_R    = drv_r & s4;
  assign Sh1_R_Out = drv_r & s2;

  assign ALUOut = (FAOut & Sum)
                | (AND   & (A & B))
                | (OR    & (A | B))
                | (XOR   & (A ^ B))
                | (NOT   & ~A)
                | (NAND  & ~(A & B))
                | (NOR   & ~(A | B))
                | (ShOut & s1);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) aluout_q <= 1'b0;
    else         aluout_q <= ALUOut;
  end

  assign ALUOutQ = aluout_q;

endmodule

// File: tb/tb_alu_bit_slice.sv
// Directed-vector bench for alu_bit_slice with hand-computed expectations.
module tb_alu_bit_slice;

  logic Clock, nReset;
  logic A, B, SUB, ZeroA, CIn_Slice, COut, Sum, FAOut, nZ_prev, nZ;
  logic AND, OR, XOR, NOT, NAND, NOR;
  logic Sh8, Sh4, Sh2, Sh1, ShB, ShL, ShR, ShOut;
  logic Sh8E_L, Sh4D_L, Sh2C_L, Sh1_L_In, Sh8D_R, Sh4C_R, Sh2B_R, Sh1_R_In;
  logic Sh8A_L, Sh4A_L, Sh2A_L, Sh1_L_Out, Sh8Z_R, Sh4Z_R, Sh2Z_R, Sh1_R_Out;
  logic ALUOut, ALUOutQ;

  int vectors = 0;
  int miscompares = 0;

  alu_bit_slice dut (
    .Clock(Clock), .nReset(nReset), .A(A), .B(B), .SUB(SUB), .ZeroA(ZeroA),
    .CIn_Slice(CIn_Slice), .COut(COut), .Sum(Sum), .FAOut(FAOut),
    .nZ_prev(nZ_prev), .nZ(nZ), .AND(AND), .OR(OR), .XOR(XOR), .NOT(NOT),
    .NAND(NAND), .NOR(NOR), .Sh8(Sh8), .Sh4(Sh4), .Sh2(Sh2), .Sh1(Sh1),
    .ShB(ShB), .ShL(ShL), .ShR(ShR), .ShOut(ShOut),
    .Sh8E_L(Sh8E_L), .Sh4D_L(Sh4D_L), .Sh2C_L(Sh2C_L), .Sh1_L_In(Sh1_L_In),
    .Sh8D_R(Sh8D_R), .Sh4C_R(Sh4C_R), .Sh2B_R(Sh2B_R), .Sh1_R_In(Sh1_R_In),
    .Sh8A_L(Sh8A_L), .Sh4A_L(Sh4A_L), .Sh2A_L(Sh2A_L), .Sh1_L_Out(Sh1_L_Out),
    .Sh8Z_R(Sh8Z_R), .Sh4Z_R(Sh4Z_R), .Sh2Z_R(Sh2Z_R), .Sh1_R_Out(Sh1_R_Out),
    .ALUOut(ALUOut), .ALUOutQ(ALUOutQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {A, B, SUB, ZeroA, CIn_Slice, FAOut, nZ_prev} = '0;
    {AND, OR, XOR, NOT, NAND, NOR} = '0;
    {Sh8, Sh4, Sh2, Sh1, ShB, ShL, ShR, ShOut} = '0;
    {Sh8E_L, Sh4D_L, Sh2C_L, Sh1_L_In, Sh8D_R, Sh4C_R, Sh2B_R, Sh1_R_In} = '0;
  endtask

  initial begin
    nReset = 1'b0;
    clear_inputs();
    #2;
    chk("reset_q", ALUOutQ, 1'b0);

    // adder
    FAOut = 1; A = 1; B = 1; CIn_Slice = 1; #1;
    chk("add111_sum", Sum, 1'b1);
    chk("add111_cout", COut, 1'b1);
    chk("add111_out", ALUOut, 1'b1);
    chk("add111_nz", nZ, 1'b1);
    ZeroA = 1; #1;
    chk("zeroa_sum", Sum, 1'b0);
    chk("zeroa_cout", COut, 1'b1);
    chk("zeroa_out", ALUOut, 1'b0);
    nZ_prev = 1; #1;
    chk("nz_prev_pass", nZ, 1'b1);
    clear_inputs();
    SUB = 1; A = 1; B = 1; CIn_Slice = 0; #1;
    chk("sub_sum", Sum, 1'b1);
    chk("sub_cout", COut, 1'b0);
    clear_inputs();
    A = 0; B = 1; CIn_Slice = 1; #1;
    chk("add011_sum", Sum, 1'b0);
    chk("add011_cout", COut, 1'b1);
    clear_inputs(); #1;
    chk("idle_out", ALUOut, 1'b0);
    chk("idle_nz", nZ, 1'b0);

    // logic ops
    clear_inputs(); AND = 1; A = 1; B = 1; #1;  chk("and11", ALUOut, 1'b1);
    A = 0; #1;                                  chk("and01", ALUOut, 1'b0);
    clear_inputs(); OR = 1; #1;                 chk("or00", ALUOut, 1'b0);
    B = 1; #1;                                  chk("or01", ALUOut, 1'b1);
    clear_inputs(); XOR = 1; A = 1; #1;         chk("xor10", ALUOut, 1'b1);
    B = 1; #1;                                  chk("xor11", ALUOut, 1'b0);
    clear_inputs(); NOT = 1; #1;                chk("not0", ALUOut, 1'b1);
    A = 1; #1;                                  chk("not1", ALUOut, 1'b0);
    clear_inputs(); NAND = 1; A = 1; B = 1; #1; chk("nand11", ALUOut, 1'b0);
    B = 0; #1;                                  chk("nand10", ALUOut, 1'b1);
    clear_inputs(); NOR = 1; #1;                chk("nor00", ALUOut, 1'b1);
    A = 1; #1;                                  chk("nor10", ALUOut, 1'b0);

    // shifter, left
    clear_inputs();
    ShOut = 1; ShL = 1; A = 1; Sh1 = 1;
    {Sh8E_L, Sh4D_L, Sh2C_L, Sh1_L_In, Sh8D_R, Sh4C_R, Sh2B_R, Sh1_R_In} = '1;
    #1;
    chk("shl_sh1_out", ALUOut, 1'b1);
    chk("shl_sh8a", Sh8A_L, 1'b1);
    chk("shl_r_quiet", Sh8Z_R, 1'b0);
    Sh1 = 0; A = 0; #1;
    chk("shl_pass_out", ALUOut, 1'b0);
    chk("shl_sh4a", Sh4A_L, 1'b0);
    A = 1; Sh8 = 1; Sh8E_L = 0; #1;
    chk("shl_s8_sh8a", Sh8A_L, 1'b1);
    chk("shl_s8_sh4a", Sh4A_L, 1'b0);
    chk("shl_s8_sh1out", Sh1_L_Out, 1'b0);
    chk("shl_s8_out", ALUOut, 1'b0);
    Sh8 = 0; Sh2 = 1; Sh2C_L = 0; Sh2B_R = 1; ShR = 1; #1;
    chk("shlr_prio_out", ALUOut, 1'b0);
    chk("shlr_prio_sh2a", Sh2A_L, 1'b1);
    chk("shlr_prio_r", Sh1_R_Out, 1'b0);
    ShL = 0; ShR = 0; Sh2 = 0; #1;
    chk("shoff_l8", Sh8A_L, 1'b0);
    chk("shoff_l1", Sh1_L_Out, 1'b0);
    chk("shoff_r8", Sh8Z_R, 1'b0);
    chk("shoff_r1", Sh1_R_Out, 1'b0);
    Sh4 = 1; #1;
    chk("shoff_sh4_zero", ALUOut, 1'b0);

    // shifter, right from B
    clear_inputs();
    ShOut = 1; ShR = 1; ShB = 1; B = 1; A = 0; #1;
    chk("shr_out", ALUOut, 1'b1);
    chk("shr_sh8z", Sh8Z_R, 1'b1);
    chk("shr_sh1out", Sh1_R_Out, 1'b1);
    chk("shr_l8", Sh8A_L, 1'b0);
    chk("shr_l4", Sh4A_L, 1'b0);
    chk("shr_l2", Sh2A_L, 1'b0);
    chk("shr_l1", Sh1_L_Out, 1'b0);
    Sh4 = 1; Sh4C_R = 0; #1;
    chk("shr_s4_sh2z", Sh2Z_R, 1'b0);
    chk("shr_s4_sh4z", Sh4Z_R, 1'b1);
    chk("shr_s4_out", ALUOut, 1'b0);

    // registered output and async reset
    clear_inputs();
    @(negedge Clock);
    nReset = 1;
    AND = 1; A = 1; B = 1;
    #1;
    chk("q_before_edge", ALUOutQ, 1'b0);
    @(posedge Clock); #1;
    chk("q_capture1", ALUOutQ, 1'b1);
    A = 0;
    @(posedge Clock); #1;
    chk("q_capture0", ALUOutQ, 1'b0);
    A = 1;
    @(posedge Clock); #1;
    chk("q_capture1b", ALUOutQ, 1'b1);
    #2 nReset = 0; #1;
    chk("q_async_reset", ALUOutQ, 1'b0);
    @(posedge Clock); #1;
    chk("q_held_reset", ALUOutQ, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
